mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/nes_mem_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_mem_pkg.sv
// Shared memory-port types: slot ownership tag and read latency.
// Used by mem_port_arbiter.
package nes_mem_pkg;

   typedef enum logic [1:0] {
      SLOT_NONE = 2'd0,
      SLOT_CPU  = 2'd1,
      SLOT_HOST = 2'd2
   } slot_tag_e;

   localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-stage (issue/capture) arbiter sharing one memory port, CPU first.
// Macro MEM_PORT_ARBITER_ROM_WP_EN: drop CPU writes to upper half, pulse cpu_wp_hit.
module mem_port_arbiter
   import nes_mem_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 8,
   parameter int MIN_CPU_PERIOD = 3
) (
   input  logic              clk_mst,
   input  logic              rst_mst_n,
   input  logic              clk_en_cpu,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_valid,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic              host_we,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
   output logic              cpu_wp_hit,
`endif
   output logic              cpu_overrun
);

   localparam int PH_W = $clog2(MIN_CPU_PERIOD + 1);
   localparam logic [PH_W-1:0] PH_MAX = PH_W'(MIN_CPU_PERIOD);
   localparam logic [PH_W-1:0] PH_LIM = PH_W'(MIN_CPU_PERIOD - 1);

   slot_tag_e         s1_tag_q, s1_tag_d;
   logic              s1_rd_q, s1_rd_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   slot_tag_e         s2_tag_q;
   logic              s2_rd_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] host_rdata_q;
   logic              host_rvalid_q;
   logic [PH_W-1:0]   phase_q;
   logic              overrun_q;
   logic              host_acc;
   logic              cpu_wp;

`ifdef MEM_PORT_ARBITER_ROM_WP_EN
   logic              wp_hit_q;
   assign cpu_wp     = cpu_we & cpu_addr[ADDR_W-1];
   assign cpu_wp_hit = wp_hit_q;
`else
   assign cpu_wp     = 1'b0;
`endif

   // Host is refused in strobe cycles and while reset is held.
   assign host_ready = rst_mst_n & ~clk_en_cpu;
   assign host_acc   = host_valid & host_ready;

   // Issue-stage next state: CPU strobe owns the slot, else accepted host.
   always_comb begin
      s1_tag_d    = SLOT_NONE;
      s1_rd_d     = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (1'b1)
         clk_en_cpu: begin
            if (!cpu_wp) begin
               s1_tag_d    = SLOT_CPU;
               s1_rd_d     = ~cpu_we;
               mem_en_d    = 1'b1;
               mem_we_d    = cpu_we;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
            end
         end
         host_acc: begin
            s1_tag_d    = SLOT_HOST;
            s1_rd_d     = ~host_we;
            mem_en_d    = 1'b1;
            mem_we_d    = host_we;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
         end
         default: ;
      endcase
   end

   // Issue and capture stages, read-data routing, phase and overrun tracking.
   always_ff @(posedge clk_mst or negedge rst_mst_n) begin
      if (!rst_mst_n) begin
         s1_tag_q      <= SLOT_NONE;
         s1_rd_q       <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         s2_tag_q      <= SLOT_NONE;
         s2_rd_q       <= 1'b0;
         cpu_rdata_q   <= '0;
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         phase_q       <= PH_MAX;
         overrun_q     <= 1'b0;
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
         wp_hit_q      <= 1'b0;
`endif
      end else begin
         s1_tag_q    <= s1_tag_d;
         s1_rd_q     <= s1_rd_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         s2_tag_q    <= s1_tag_q;
         s2_rd_q     <= s1_rd_q;
         if (s2_rd_q && s2_tag_q == SLOT_CPU) begin
            cpu_rdata_q <= mem_rdata;
         end
         if (s2_rd_q && s2_tag_q == SLOT_HOST) begin
            host_rdata_q <= mem_rdata;
         end
         host_rvalid_q <= s2_rd_q && (s2_tag_q == SLOT_HOST);
         if (clk_en_cpu) begin
            phase_q <= '0;
         end else if (phase_q != PH_MAX) begin
            phase_q <= phase_q + PH_W'(1);
         end
         if (clk_en_cpu && phase_q < PH_LIM) begin
            overrun_q <= 1'b1;
         end
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
         wp_hit_q <= clk_en_cpu & cpu_wp;
`endif
      end
   end

   assign mem_en      = mem_en_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign host_rdata  = host_rdata_q;
   assign host_rvalid = host_rvalid_q;
   assign cpu_overrun = overrun_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random + directed bench for mem_port_arbiter against a cycle-schedule model.
// Honours MEM_PORT_ARBITER_ROM_WP_EN when defined.
module tb_mem_port_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 8;
   localparam int MINP = 3;
   localparam int N    = 4096;
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stb_i;
   logic [AW-1:0] cpu_addr;
   logic          cpu_we;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          host_valid;
   logic [AW-1:0] host_addr;
   logic          host_we;
   logic [DW-1:0] host_wdata;
   logic          host_ready;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          cpu_overrun;
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
   logic          cpu_wp_hit;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MIN_CPU_PERIOD(MINP)
   ) dut (
      .clk_mst(clk),
      .rst_mst_n(rst_n),
      .clk_en_cpu(stb_i),
      .cpu_addr(cpu_addr),
      .cpu_we(cpu_we),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .host_valid(host_valid),
      .host_addr(host_addr),
      .host_we(host_we),
      .host_wdata(host_wdata),
      .host_ready(host_ready),
      .host_rvalid(host_rvalid),
      .host_rdata(host_rdata),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
      .cpu_wp_hit(cpu_wp_hit),
`endif
      .cpu_overrun(cpu_overrun)
   );

   // memory with one-cycle read latency
   logic [DW-1:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         else mem_rdata <= mem[mem_addr];
      end
   end

   // reference model: expected port activity scheduled per cycle
   logic [DW-1:0] shadow [0:65535];
   bit            e_en  [0:N-1];
   bit            e_we  [0:N-1];
   logic [AW-1:0] e_ad  [0:N-1];
   logic [DW-1:0] e_wd  [0:N-1];
   bit            e_cu  [0:N-1];
   logic [DW-1:0] e_cv  [0:N-1];
   bit            e_hv  [0:N-1];
   logic [DW-1:0] e_hd  [0:N-1];
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
   bit            e_wp  [0:N-1];
`endif
   int            cyc;
   int            last_stb;
   bit            ovr;
   logic [DW-1:0] cur_c;
   logic [DW-1:0] cur_h;
   int            total = 0;
   int            bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0d: got %0h want %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic clr_model();
      for (int i = 0; i < N; i++) begin
         e_en[i] = 0; e_we[i] = 0; e_ad[i] = '0; e_wd[i] = '0;
         e_cu[i] = 0; e_cv[i] = '0; e_hv[i] = 0; e_hd[i] = '0;
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
         e_wp[i] = 0;
`endif
      end
      last_stb = -100;
      ovr      = 0;
      cur_c    = '0;
      cur_h    = '0;
   endtask

   task automatic chk_rst();
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_host_rdata", host_rdata, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_overrun", cpu_overrun, 0);
      chk("rst_host_ready", host_ready, 0);
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
      chk("rst_wp_hit", cpu_wp_hit, 0);
`endif
   endtask

   // one cycle: check outputs against the schedule, drive inputs, schedule
   task automatic step(input bit stb, input bit cwe, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cwd, input bit hv, input bit hwe,
                       input logic [AW-1:0] ha, input logic [DW-1:0] hwd,
                       output bit acc);
      int k;
      bit wp;
      @(negedge clk);
      cyc++;
      if (e_cu[cyc]) cur_c = e_cv[cyc];
      if (e_hv[cyc]) cur_h = e_hd[cyc];
      chk("mem_en", mem_en, e_en[cyc]);
      chk("mem_we", mem_we, e_we[cyc]);
      if (e_en[cyc]) chk("mem_addr", mem_addr, e_ad[cyc]);
      if (e_en[cyc] && e_we[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
      chk("host_rvalid", host_rvalid, e_hv[cyc]);
      chk("host_rdata", host_rdata, cur_h);
      chk("cpu_rdata", cpu_rdata, cur_c);
      chk("cpu_overrun", cpu_overrun, ovr);
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
      chk("cpu_wp_hit", cpu_wp_hit, e_wp[cyc]);
`endif
      stb_i = stb; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
      host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hwd;
      #1;
      chk("host_ready", host_ready, !stb);
      acc = hv && !stb;
      k = cyc + 1;
      if (stb) begin
         if (cyc - last_stb < MINP) ovr = 1;
         last_stb = cyc;
         wp = WP && cwe && ca[AW-1];
         if (wp) begin
`ifdef MEM_PORT_ARBITER_ROM_WP_EN
            e_wp[k] = 1;
`endif
         end else begin
            e_en[k] = 1; e_we[k] = cwe; e_ad[k] = ca; e_wd[k] = cwd;
            if (cwe) shadow[ca] = cwd;
            else begin
               e_cu[cyc+3] = 1;
               e_cv[cyc+3] = shadow[ca];
            end
         end
      end else if (hv) begin
         e_en[k] = 1; e_we[k] = hwe; e_ad[k] = ha; e_wd[k] = hwd;
         if (hwe) shadow[ha] = hwd;
         else begin
            e_hv[cyc+3] = 1;
            e_hd[cyc+3] = shadow[ha];
         end
      end
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, a);
   endtask

   function automatic logic [AW-1:0] raddr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = a | 16'h8000;
      return a;
   endfunction

   initial begin
      bit            a;
      int            idx;
      int            n;
      logic [DW-1:0] keep;
      for (int i = 0; i < 65536; i++) begin
         mem[i]    = 8'(i ^ (i >> 8) ^ 8'hA5);
         shadow[i] = mem[i];
      end
      rst_n = 0; stb_i = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      host_valid = 1; host_we = 0; host_addr = '0; host_wdata = '0;
      cyc = 0;
      clr_model();
      #12;
      chk_rst();
      host_valid = 0;
      @(negedge clk);
      rst_n = 1;

      // CPU read of 0x0123 returning 0x5A
      mem[16'h0123] = 8'h5A; shadow[16'h0123] = 8'h5A;
      step(1, 0, 16'h0123, '0, 0, 0, '0, '0, a);
      idle(3);
      chk("cpu_read_5a", cpu_rdata, 8'h5A);
      idle(3);

      // host in a strobe cycle waits one cycle
      step(1, 0, 16'h0300, '0, 1, 0, 16'h0200, '0, a);
      step(0, 0, '0, '0, 1, 0, 16'h0200, '0, a);
      idle(4);

      // held host reads 0x10..0x13 with periodic strobes
      idx = 0; n = 0;
      while (idx < 4 && n < 40) begin
         step((n % 12) == 1, 0, 16'h0040, '0, 1, 0, AW'(16 + idx), '0, a);
         if (a) idx++;
         n++;
      end
      chk("burst_accepts", idx, 4);
      idle(5);

      // ROM write-protect probe
      keep = mem[16'h8000];
      step(1, 1, 16'h8000, 8'hFF, 0, 0, '0, '0, a);
      idle(4);
      chk("rom_wp_mem", mem[16'h8000], WP ? keep : 8'hFF);

      // randomized traffic with legal strobe spacing
      for (int i = 0; i < 900; i++) begin
         bit s;
         s = (cyc + 1 - last_stb >= MINP) && ($urandom_range(0, 3) == 0);
         step(s, 1'($urandom), raddr(), 8'($urandom),
              $urandom_range(0, 2) != 0, 1'($urandom), raddr(),
              8'($urandom), a);
      end
      idle(4);
      chk("no_overrun", cpu_overrun, 0);

      // strobes two cycles apart raise sticky overrun, both issue
      step(1, 0, 16'h0005, '0, 0, 0, '0, '0, a);
      step(0, 0, '0, '0, 0, 0, '0, '0, a);
      step(1, 0, 16'h0006, '0, 0, 0, '0, '0, a);
      idle(8);
      chk("overrun_sticky", cpu_overrun, 1);

      // reset while a host read is in flight
      step(0, 0, '0, '0, 1, 0, 16'h0007, '0, a);
      @(negedge clk);
      rst_n = 0;
      #1;
      chk_rst();
      @(negedge clk);
      @(negedge clk);
      chk_rst();
      host_valid = 0;
      rst_n = 1;
      cyc += 3;
      clr_model();
      idle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
